ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch unit for the single-issue core. It produces the `ifToId_t` stream that the decode stage consumes, and drives a single-outstanding request/response port toward instruction memory. A `QDEPTH`-entry fetch queue decouples memory latency from decode back-pressure. An EX-stage redirect flushes the queue and restarts fetch.

## Interface
- `RESET_PC`, default `32'h8000_0000`: first fetch address after reset.
- `QDEPTH`, default 2: fetch-queue entries; must be a power of two and ≥ 2.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `mem_req_valid` out 1: fetch request valid.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_addr` out `ADDR_WIDTH` (32): word address of the fetch.
- `mem_resp_valid` in 1: response valid. Responses arrive in order, ≥1 cycle after acceptance.
- `mem_resp_data` in `DATA_WIDTH` (32): instruction word.
- `mem_resp_ready` out 1: tied to 1.
- `redirect_valid` in 1: flush-and-restart request from EX.
- `redirect_pc` in 32: new fetch PC; bits [1:0] are ignored and forced to 0.
- `if_valid` out 1: queue head valid toward decode.
- `if_ready` in 1: decode accepts the head.
- `if_data` out `$bits(ifToId_t)` (64): `{pc, inst}` of the head entry.
- `fetch_cnt` out 32: count of instructions enqueued since reset; wraps modulo 2^32.

## Operation
- **State.** `fetch_pc`, `req_pc`, FSM state, queue storage, `utils::ptr_t`-style pointers `{flag, idx}` with `idx` of width log2(`QDEPTH`), and `fetch_cnt`.
- **Queue status.**
  - Empty when the write pointer equals the read pointer.
  - Full when the indices are equal and the flags differ.
  - When an index wraps from `QDEPTH-1` to 0, its flag toggles.
- **FSM state REQ.**
  - `mem_req_valid = !full`; `mem_req_addr = fetch_pc`.
  - On a request handshake: `req_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 4` (wraps mod 2^32), go to WAIT.
- **FSM state WAIT.**
  - `mem_req_valid = 0`.
  - On `mem_resp_valid`: enqueue `{req_pc, mem_resp_data}`, increment `fetch_cnt`, go to REQ.
  - The queue cannot overflow: a request issues only when the queue is not full, and only one request is outstanding.
- **FSM state DROP.** `mem_req_valid = 0`. On `mem_resp_valid`: discard the data (no enqueue, no count), go to REQ.
- **Dequeue.** `if_valid = !empty`; `if_data` = head entry, or 0 when empty. On `if_valid && if_ready` the read pointer advances.
- **Redirect.** Redirect has priority over every other event in the same cycle.
  - Both pointers reset to 0 with flags cleared, so the queue is empty next cycle.
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - Next state depends on the state during the redirect cycle:
    - REQ without handshake → REQ. `mem_req_valid` may still be high that cycle, but that request is not accepted.
    - REQ with handshake → DROP.
    - WAIT without response → DROP.
    - WAIT with response → REQ, response discarded.
    - DROP without response → DROP.
    - DROP with response → REQ.
  - A dequeue handshake in the redirect cycle is still honored at the interface; the queue is cleared regardless.
- **Simultaneous enqueue and dequeue.** Both apply in the same cycle; occupancy is unchanged.

## Timing
- **Reset values.** While `rst` is high: `mem_req_valid = 0`, `if_valid = 0`. After the reset edge:
  - `if_data = 0`, `fetch_cnt = 0`.
  - `mem_req_addr = RESET_PC`, state = REQ, queue empty.
  - `mem_resp_ready = 1` always.
- **Reset mid-operation.** Returns to the state above at the next edge. Any response to a request outstanding before reset must not arrive after reset; the memory is reset together with this block.
- **First request.** `mem_req_valid = 1` in the first cycle with `rst` low.
- **Latency.**
  - Request accepted in cycle N, response in cycle N+k (k ≥ 1): entry is visible as `if_valid` in cycle N+k+1.
  - With `mem_req_ready = 1` and k = 1, throughput is one instruction every 2 cycles.
- **Output types.** `mem_req_valid` and `mem_req_addr` are combinational from registered state, `full`, and `rst`. `if_valid` and `if_data` come only from registers. There is no combinational path from `if_ready` or `mem_resp_valid` to any output.
- **Redirect latency.** A redirect in cycle R produces `mem_req_valid` with `mem_req_addr = redirect_pc` in cycle R+1 if state becomes REQ. If state becomes DROP, it happens in the cycle after the dropped response.

## Test plan
- **Reset fetch.** Release reset; memory has ready = 1, 1-cycle response, data = addr ^ `32'hA5A5_A5A5`; `if_ready` = 1. Required response:
  - Request addresses `0x8000_0000`, `0x8000_0004`, `0x8000_0008`.
  - Decode sees pc/inst pairs in order, one every 2 cycles; `fetch_cnt` = 3 after the third enqueue.
- **Back-pressure.** Hold `if_ready` = 0. Required response:
  - Exactly 2 instructions are enqueued; then `mem_req_valid` stays 0.
  - Raising `if_ready` drains 0x8000_0000 then 0x8000_0004, then fetch resumes at 0x8000_0008.
- **Redirect while waiting.** Redirect to 0x8000_0100 while in WAIT, with the response arriving 3 cycles later. Required response:
  - That response is dropped.
  - The next request is at 0x8000_0100; the old pc never appears at decode.
- **Simultaneous redirect and response.** Redirect to 0x8000_0200 in the same cycle as `mem_resp_valid`. Required response:
  - No enqueue; `fetch_cnt` unchanged.
  - Next cycle: `mem_req_valid = 1` with addr 0x8000_0200.
- **Redirect on handshake, misaligned target, pointer wrap.** Redirect to 0x8000_0303 in a REQ handshake cycle. Required response:
  - DROP discards the in-flight response; the next request is at 0x8000_0300.
  - Over 10 fetch/dequeue rounds the queue never reports full falsely, and pointer flags toggle on each wrap.
- **Mid-stream reset.** Assert `rst` with 2 entries queued. Required response:
  - `if_valid = 0` and `mem_req_valid = 0` while `rst` is high.
  - After release, the first request is at 0x8000_0000 and `fetch_cnt = 0`.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-outstanding memory fetch feeding a small
// pointer-based queue toward decode, with EX redirect flush-and-restart.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic        mem_resp_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [63:0] if_data,
   output logic [31:0] fetch_cnt
);
   localparam int IDXW = $clog2(QDEPTH);
   localparam logic [IDXW:0] PTR_ONE = 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } if_to_id_t;

   typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_DROP} state_t;

   state_t        state_reg, state_next;
   logic [31:0]   fetch_pc_reg, fetch_pc_next;
   logic [31:0]   req_pc_reg;
   logic [31:0]   fetch_cnt_reg;
   logic [IDXW:0] wptr_reg, rptr_reg;
   if_to_id_t     q_mem [QDEPTH];

   logic empty, full, req_fire, enq, deq;

   // Pointers carry a wrap flag above the index so full and empty differ.
   assign empty = (wptr_reg == rptr_reg);
   assign full  = (wptr_reg[IDXW-1:0] == rptr_reg[IDXW-1:0]) &&
                  (wptr_reg[IDXW] != rptr_reg[IDXW]);

   assign mem_req_valid  = !rst && (state_reg == ST_REQ) && !full;
   assign mem_req_addr   = fetch_pc_reg;
   assign mem_resp_ready = 1'b1;
   assign req_fire       = mem_req_valid && mem_req_ready;

   assign if_valid  = !empty;
   assign if_data   = empty ? 64'd0 : q_mem[rptr_reg[IDXW-1:0]];
   assign deq       = if_valid && if_ready;
   assign fetch_cnt = fetch_cnt_reg;

   always_comb begin
      state_next    = state_reg;
      fetch_pc_next = fetch_pc_reg;
      enq           = 1'b0;
      case (state_reg)
         ST_REQ: begin
            if (req_fire) begin
               state_next    = ST_WAIT;
               fetch_pc_next = fetch_pc_reg + 32'd4;
            end
         end
         ST_WAIT: begin
            if (mem_resp_valid) begin
               state_next = ST_REQ;
               enq        = 1'b1;
            end
         end
         ST_DROP: begin
            if (mem_resp_valid) state_next = ST_REQ;
         end
         default: state_next = ST_REQ;
      endcase
      // A redirect kills any enqueue; an in-flight request must be drained in DROP.
      if (redirect_valid) begin
         enq           = 1'b0;
         fetch_pc_next = redirect_pc & ~32'h3;
         if (state_reg == ST_REQ) state_next = req_fire ? ST_DROP : ST_REQ;
         else                     state_next = mem_resp_valid ? ST_REQ : ST_DROP;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_REQ;
         fetch_pc_reg  <= RESET_PC;
         req_pc_reg    <= RESET_PC;
         fetch_cnt_reg <= 32'd0;
         wptr_reg      <= '0;
         rptr_reg      <= '0;
      end else begin
         state_reg    <= state_next;
         fetch_pc_reg <= fetch_pc_next;
         if (req_fire) req_pc_reg <= fetch_pc_reg;
         if (enq) fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
         if (redirect_valid) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
         end else begin
            if (enq) wptr_reg <= wptr_reg + PTR_ONE;
            if (deq) rptr_reg <= rptr_reg + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (enq) q_mem[wptr_reg[IDXW-1:0]] <= '{pc: req_pc_reg, inst: mem_resp_data};
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: behavioural instruction memory with
// configurable latency, hand-computed checks sampled at the falling edge.
module tb_ifu_fetch;
   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        mem_resp_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [63:0] if_data;
   logic [31:0] fetch_cnt;

   int checks = 0;
   int errors = 0;
   int lat    = 1;

   ifu_fetch #(.RESET_PC(32'h8000_0000), .QDEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .mem_resp_ready(mem_resp_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ready(if_ready), .if_data(if_data),
      .fetch_cnt(fetch_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ent(input logic [31:0] pc);
      return {pc, pc ^ 32'hA5A5_A5A5};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic do_reset();
      redirect_valid = 1'b0;
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   // Memory model: in-order, one outstanding, response lat cycles after acceptance.
   initial begin
      logic        pend;
      logic [31:0] pa;
      int          cd;
      pend = 1'b0; pa = '0; cd = 0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      forever begin
         @(negedge clk);
         #1;
         mem_resp_valid = 1'b0;
         if (rst) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               if (cd <= 1) begin
                  mem_resp_valid = 1'b1;
                  mem_resp_data  = pa ^ 32'hA5A5_A5A5;
                  pend = 1'b0;
               end else begin
                  cd--;
               end
            end
            if (mem_req_valid && mem_req_ready) begin
               pend = 1'b1;
               pa   = mem_req_addr;
               cd   = lat;
               $display("t=%0t mem req addr=%h", $time, mem_req_addr);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; mem_req_ready = 1'b1; redirect_valid = 1'b0;
      redirect_pc = '0; if_ready = 1'b0;

      // Reset state
      cyc(); cyc();
      chk("rst_req_valid", mem_req_valid, 1'b0);
      chk("rst_if_valid", if_valid, 1'b0);
      chk("rst_if_data", if_data, 64'd0);
      chk("rst_fetch_cnt", fetch_cnt, 32'd0);
      chk("rst_req_addr", mem_req_addr, 32'h8000_0000);
      chk("resp_ready", mem_resp_ready, 1'b1);

      // Reset fetch: one instruction every 2 cycles
      if_ready = 1'b1; lat = 1; rst = 1'b0;
      #1;
      chk("t1_c0_valid", mem_req_valid, 1'b1);
      chk("t1_c0_addr", mem_req_addr, 32'h8000_0000);
      cyc();
      chk("t1_c1_wait", mem_req_valid, 1'b0);
      chk("t1_c1_ifv", if_valid, 1'b0);
      cyc();
      chk("t1_c2_data", if_data, ent(32'h8000_0000));
      chk("t1_c2_addr", mem_req_addr, 32'h8000_0004);
      chk("t1_c2_valid", mem_req_valid, 1'b1);
      chk("t1_c2_cnt", fetch_cnt, 32'd1);
      cyc();
      chk("t1_c3_ifv", if_valid, 1'b0);
      cyc();
      chk("t1_c4_data", if_data, ent(32'h8000_0004));
      cyc(); cyc();
      chk("t1_c6_data", if_data, ent(32'h8000_0008));
      chk("t1_c6_cnt", fetch_cnt, 32'd3);

      // Back-pressure: two entries fill the queue, then fetch stalls
      if_ready = 1'b0;
      do_reset();
      #1;
      chk("t2_c0_addr", mem_req_addr, 32'h8000_0000);
      cyc(); cyc();
      chk("t2_c2_data", if_data, ent(32'h8000_0000));
      chk("t2_c2_addr", mem_req_addr, 32'h8000_0004);
      cyc(); cyc();
      chk("t2_c4_full", mem_req_valid, 1'b0);
      chk("t2_c4_cnt", fetch_cnt, 32'd2);
      chk("t2_c4_head", if_data, ent(32'h8000_0000));
      cyc();
      chk("t2_c5_full", mem_req_valid, 1'b0);
      cyc();
      chk("t2_c6_full", mem_req_valid, 1'b0);
      if_ready = 1'b1;
      cyc();
      chk("t2_c7_data", if_data, ent(32'h8000_0004));
      chk("t2_c7_valid", mem_req_valid, 1'b1);
      chk("t2_c7_addr", mem_req_addr, 32'h8000_0008);
      cyc();
      chk("t2_c8_ifv", if_valid, 1'b0);
      cyc();
      chk("t2_c9_data", if_data, ent(32'h8000_0008));
      chk("t2_c9_cnt", fetch_cnt, 32'd3);

      // Redirect while waiting, response 3 cycles after acceptance
      lat = 3;
      do_reset();
      #1;
      chk("t3_c0_addr", mem_req_addr, 32'h8000_0000);
      cyc();
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
      cyc();
      redirect_valid = 1'b0;
      chk("t3_c2_drop", mem_req_valid, 1'b0);
      cyc();
      chk("t3_c3_drop", mem_req_valid, 1'b0);
      cyc();
      chk("t3_c4_valid", mem_req_valid, 1'b1);
      chk("t3_c4_addr", mem_req_addr, 32'h8000_0100);
      chk("t3_c4_ifv", if_valid, 1'b0);
      chk("t3_c4_cnt", fetch_cnt, 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t3_no_old_pc", if_valid, 1'b0);
      end
      cyc();
      chk("t3_c8_data", if_data, ent(32'h8000_0100));
      chk("t3_c8_cnt", fetch_cnt, 32'd1);

      // Redirect in the same cycle as the response
      lat = 1;
      do_reset();
      #1;
      chk("t4_c0_addr", mem_req_addr, 32'h8000_0000);
      cyc();
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
      cyc();
      redirect_valid = 1'b0;
      chk("t4_c2_valid", mem_req_valid, 1'b1);
      chk("t4_c2_addr", mem_req_addr, 32'h8000_0200);
      chk("t4_c2_cnt", fetch_cnt, 32'd0);
      chk("t4_c2_ifv", if_valid, 1'b0);
      cyc(); cyc();
      chk("t4_c4_data", if_data, ent(32'h8000_0200));
      chk("t4_c4_cnt", fetch_cnt, 32'd1);

      // Redirect on a request handshake with a misaligned target, then wrap rounds
      do_reset();
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0303;
      #1;
      chk("t5_c0_valid", mem_req_valid, 1'b1);
      cyc();
      redirect_valid = 1'b0;
      chk("t5_c1_drop", mem_req_valid, 1'b0);
      chk("t5_c1_ifv", if_valid, 1'b0);
      cyc();
      chk("t5_c2_valid", mem_req_valid, 1'b1);
      chk("t5_c2_addr", mem_req_addr, 32'h8000_0300);
      chk("t5_c2_cnt", fetch_cnt, 32'd0);
      for (int i = 0; i < 10; i++) begin
         cyc(); cyc();
         chk("t5_round_data", if_data, ent(32'h8000_0300 + 32'(4 * i)));
         chk("t5_round_notfull", mem_req_valid, 1'b1);
         chk("t5_round_cnt", fetch_cnt, 32'(i + 1));
         if (i == 9) if_ready = 1'b0;
      end
      cyc(); cyc();
      chk("t5_wrap_full", mem_req_valid, 1'b0);
      chk("t5_wrap_cnt", fetch_cnt, 32'd11);
      chk("t5_wrap_head", if_data, ent(32'h8000_0324));
      cyc();
      chk("t5_wrap_full2", mem_req_valid, 1'b0);

      // Mid-stream reset with two entries queued
      rst = 1'b1;
      #1;
      chk("t6_rst_req_valid", mem_req_valid, 1'b0);
      cyc();
      chk("t6_rst_if_valid", if_valid, 1'b0);
      chk("t6_rst_req_valid2", mem_req_valid, 1'b0);
      chk("t6_rst_if_data", if_data, 64'd0);
      chk("t6_rst_cnt", fetch_cnt, 32'd0);
      rst = 1'b0;
      #1;
      chk("t6_first_valid", mem_req_valid, 1'b1);
      chk("t6_first_addr", mem_req_addr, 32'h8000_0000);
      chk("t6_first_cnt", fetch_cnt, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
